// File: rtl/psx_controller_emu_if.sv
// psx_controller_emu_if: serial PSX link between console (master) and controller (slave).
// psx_clk idles high, att and ack are active low, data and cmd are sent LSB first.
interface psx_controller_emu_if;
  logic psx_clk;
  logic att;
  logic cmd;
  logic data;
  logic ack;

  modport master (output psx_clk, att, cmd, input data, ack);
  modport slave (input psx_clk, att, cmd, output data, ack);
endinterface

// File: rtl/psx_controller_emu.sv
// psx_controller_emu: PlayStation controller emulator that oversamples the link on clk.
// Define PSX_ANALOG_EN to build the analog-mode (ID 0x73, 9-byte) response path.
module psx_controller_emu #(
  parameter int unsigned ACK_DELAY = 4,
  parameter int unsigned ACK_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  psx_controller_emu_if.slave link,
  input  logic [15:0]         buttons,
  input  logic [31:0]         sticks,
  input  logic                analog_mode,
  output logic                busy
);

  typedef enum logic [2:0] {IDLE, ADDR, CMD, RESP, DONE} state_t;
  typedef enum logic [1:0] {ACK_IDLE, ACK_WAIT, ACK_LOW} ack_state_t;

  localparam logic [7:0] DELAY_LOAD = 8'(ACK_DELAY - 1);
  localparam logic [7:0] WIDTH_LOAD = 8'(ACK_WIDTH);

  logic [1:0]  psx_clk_sync, att_sync, cmd_sync;
  logic        psx_clk_prev, att_prev;
  logic        clk_rise, clk_fall, att_rise, att_fall, cmd_bit;

  state_t      state, state_n;
  ack_state_t  ack_state, ack_state_n;
  logic [2:0]  bit_cnt, bit_cnt_n;
  logic [3:0]  byte_cnt, byte_cnt_n, byte_next, last_byte;
  logic [6:0]  rx_sr, rx_sr_n;
  logic [7:0]  rx_byte, tx_sr, tx_sr_n, next_reply, id_byte;
  logic [7:0]  ack_cnt, ack_cnt_n;
  logic        data_q, data_n, ack_q, ack_n, ack_trig, capture;
  logic [15:0] buttons_q;
  logic        mode_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      psx_clk_sync <= 2'b11;
      att_sync     <= 2'b11;
      cmd_sync     <= 2'b11;
      psx_clk_prev <= 1'b1;
      att_prev     <= 1'b1;
    end else begin
      psx_clk_sync <= {psx_clk_sync[0], link.psx_clk};
      att_sync     <= {att_sync[0], link.att};
      cmd_sync     <= {cmd_sync[0], link.cmd};
      psx_clk_prev <= psx_clk_sync[1];
      att_prev     <= att_sync[1];
    end
  end

  assign clk_rise = psx_clk_sync[1] & ~psx_clk_prev;
  assign clk_fall = ~psx_clk_sync[1] & psx_clk_prev;
  assign att_rise = att_sync[1] & ~att_prev;
  assign att_fall = ~att_sync[1] & att_prev;
  assign cmd_bit  = cmd_sync[1];

  // Inputs are frozen at the start of each transaction so the reply is self-consistent.
  always_ff @(posedge clk) begin
    if (rst) begin
      buttons_q <= '0;
    end else if (capture) begin
      buttons_q <= buttons;
    end
  end

`ifdef PSX_ANALOG_EN
  logic [31:0] sticks_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sticks_q <= '0;
      mode_q   <= 1'b0;
    end else if (capture) begin
      sticks_q <= sticks;
      mode_q   <= analog_mode;
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = ^{sticks, analog_mode};
  assign mode_q = 1'b0;
`endif

  always_comb begin
    byte_next  = byte_cnt + 4'd1;
    last_byte  = mode_q ? 4'd8 : 4'd4;
    id_byte    = mode_q ? 8'h73 : 8'h41;
    next_reply = 8'h5A;
    case (byte_next)
      4'd3:    next_reply = buttons_q[7:0];
      4'd4:    next_reply = buttons_q[15:8];
`ifdef PSX_ANALOG_EN
      4'd5:    next_reply = sticks_q[7:0];
      4'd6:    next_reply = sticks_q[15:8];
      4'd7:    next_reply = sticks_q[23:16];
      4'd8:    next_reply = sticks_q[31:24];
`endif
      default: next_reply = 8'h5A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ack_state <= ACK_IDLE;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      rx_sr     <= '0;
      tx_sr     <= 8'hFF;
      ack_cnt   <= '0;
      data_q    <= 1'b1;
      ack_q     <= 1'b1;
    end else begin
      state     <= state_n;
      ack_state <= ack_state_n;
      bit_cnt   <= bit_cnt_n;
      byte_cnt  <= byte_cnt_n;
      rx_sr     <= rx_sr_n;
      tx_sr     <= tx_sr_n;
      ack_cnt   <= ack_cnt_n;
      data_q    <= data_n;
      ack_q     <= ack_n;
    end
  end

  // att rising takes priority over any psx_clk edge seen in the same cycle.
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    byte_cnt_n = byte_cnt;
    rx_sr_n    = rx_sr;
    tx_sr_n    = tx_sr;
    data_n     = data_q;
    ack_trig   = 1'b0;
    capture    = 1'b0;
    rx_byte    = {cmd_bit, rx_sr};

    if (att_rise) begin
      state_n = IDLE;
      data_n  = 1'b1;
    end else if (att_fall) begin
      capture    = 1'b1;
      state_n    = ADDR;
      bit_cnt_n  = '0;
      byte_cnt_n = '0;
      tx_sr_n    = 8'hFF;
      data_n     = 1'b1;
    end else if (state inside {ADDR, CMD, RESP}) begin
      if (clk_fall) begin
        data_n  = tx_sr[0];
        tx_sr_n = {1'b1, tx_sr[7:1]};
      end else if (clk_rise) begin
        rx_sr_n   = rx_byte[7:1];
        bit_cnt_n = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_cnt_n = byte_next;
          case (state)
            ADDR: begin
              if (rx_byte == 8'h01) begin
                state_n  = CMD;
                tx_sr_n  = id_byte;
                ack_trig = 1'b1;
              end else begin
                state_n = DONE;
                data_n  = 1'b1;
              end
            end
            CMD: begin
              if (rx_byte == 8'h42) begin
                state_n  = RESP;
                tx_sr_n  = 8'h5A;
                ack_trig = 1'b1;
              end else begin
                state_n = DONE;
                data_n  = 1'b1;
              end
            end
            default: begin
              if (byte_cnt == last_byte) begin
                state_n = DONE;
                data_n  = 1'b1;
              end else begin
                tx_sr_n  = next_reply;
                ack_trig = 1'b1;
              end
            end
          endcase
        end
      end
    end

    ack_state_n = ack_state;
    ack_cnt_n   = ack_cnt;
    ack_n       = ack_q;
    if (att_rise) begin
      ack_state_n = ACK_IDLE;
      ack_cnt_n   = '0;
      ack_n       = 1'b1;
    end else begin
      case (ack_state)
        ACK_IDLE: begin
          if (ack_trig) begin
            if (ACK_DELAY == 1) begin
              ack_state_n = ACK_LOW;
              ack_cnt_n   = WIDTH_LOAD;
              ack_n       = 1'b0;
            end else begin
              ack_state_n = ACK_WAIT;
              ack_cnt_n   = DELAY_LOAD;
            end
          end
        end
        ACK_WAIT: begin
          if (ack_cnt == 8'd1) begin
            ack_state_n = ACK_LOW;
            ack_cnt_n   = WIDTH_LOAD;
            ack_n       = 1'b0;
          end else begin
            ack_cnt_n = ack_cnt - 8'd1;
          end
        end
        ACK_LOW: begin
          if (ack_cnt == 8'd1) begin
            ack_state_n = ACK_IDLE;
            ack_cnt_n   = '0;
            ack_n       = 1'b1;
          end else begin
            ack_cnt_n = ack_cnt - 8'd1;
          end
        end
        default: begin
          ack_state_n = ACK_IDLE;
          ack_n       = 1'b1;
        end
      endcase
    end
  end

  assign link.data = data_q;
  assign link.ack  = ack_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_psx_controller_emu.sv
// tb_psx_controller_emu: directed console-side polls against psx_controller_emu.
// Each byte's reply bits and ack delay/width are compared to hand-computed values.
module tb_psx_controller_emu;

  localparam int TB_ACK_DELAY = 4;
  localparam int TB_ACK_WIDTH = 8;
  localparam int HALF_BIT     = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] buttons;
  logic [31:0] sticks;
  logic        analog_mode;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] txQ  [9];
  logic [7:0] expQ [9];
  logic       ackQ [9];

  psx_controller_emu_if ifc ();

  psx_controller_emu #(
    .ACK_DELAY(TB_ACK_DELAY),
    .ACK_WIDTH(TB_ACK_WIDTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .link       (ifc),
    .buttons    (buttons),
    .sticks     (sticks),
    .analog_mode(analog_mode),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One byte on the link: psx_clk low HALF_BIT clocks, sample data, raise psx_clk.
  task automatic applyStimulus(input string tag, input logic [7:0] txByte,
                               input logic [7:0] expByte, input bit expAck,
                               input bit abortOnAck);
    logic [7:0] rxByte;
    int         firstLow;
    int         lowCnt;
    bit         stop;
    rxByte   = '0;
    firstLow = 0;
    lowCnt   = 0;
    stop     = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ifc.psx_clk = 1'b0;
      ifc.cmd     = txByte[i];
      repeat (HALF_BIT) @(negedge clk);
      rxByte[i]   = ifc.data;
      ifc.psx_clk = 1'b1;
      if (i < 7) repeat (HALF_BIT) @(negedge clk);
    end
    checkOutput($sformatf("%s_data", tag), 32'(rxByte), 32'(expByte));
    for (int k = 1; k <= 40 && !stop; k++) begin
      @(negedge clk);
      if (ifc.ack === 1'b0) begin
        if (firstLow == 0) firstLow = k;
        lowCnt++;
      end
      if (abortOnAck && firstLow != 0) begin
        ifc.att = 1'b1;
        stop    = 1'b1;
      end
    end
    if (expAck) begin
      checkOutput($sformatf("%s_ackDelay", tag), 32'(firstLow), 32'(TB_ACK_DELAY + 2));
      if (!abortOnAck)
        checkOutput($sformatf("%s_ackWidth", tag), 32'(lowCnt), 32'(TB_ACK_WIDTH));
    end else begin
      checkOutput($sformatf("%s_noAck", tag), 32'(lowCnt), 32'd0);
    end
  endtask

  task automatic doPoll(input string tag, input int nBytes, input logic [15:0] lateButtons);
    @(negedge clk);
    ifc.att = 1'b0;
    repeat (16) @(negedge clk);
    buttons = lateButtons;
    checkOutput($sformatf("%s_busy", tag), 32'(busy), 32'd1);
    for (int i = 0; i < nBytes; i++)
      applyStimulus($sformatf("%s_b%0d", tag, i), txQ[i], expQ[i], ackQ[i], 1'b0);
    checkOutput($sformatf("%s_dataDone", tag), 32'(ifc.data), 32'd1);
    checkOutput($sformatf("%s_busyDone", tag), 32'(busy), 32'd1);
    @(negedge clk);
    ifc.att = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput($sformatf("%s_busyIdle", tag), 32'(busy), 32'd0);
    checkOutput($sformatf("%s_ackIdle", tag), 32'(ifc.ack), 32'd1);
    repeat (12) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    rst         = 1'b1;
    ifc.psx_clk = 1'b1;
    ifc.att     = 1'b1;
    ifc.cmd     = 1'b1;
    buttons     = 16'hFFFF;
    sticks      = 32'h8080_8080;
    analog_mode = 1'b0;

    repeat (4) @(negedge clk);
    checkOutput("reset_data", 32'(ifc.data), 32'd1);
    checkOutput("reset_ack", 32'(ifc.ack), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("post_reset_busy", 32'(busy), 32'd0);

    $display("[TB] digital poll");
    buttons = 16'hFDFE;
    txQ  = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    expQ = '{8'hFF, 8'h41, 8'h5A, 8'hFE, 8'hFD, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    ackQ = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    doPoll("digital", 5, 16'h0000);

`ifdef PSX_ANALOG_EN
    $display("[TB] analog poll");
    buttons     = 16'hFDFE;
    sticks      = 32'h807F_10F0;
    analog_mode = 1'b1;
    txQ  = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    expQ = '{8'hFF, 8'h73, 8'h5A, 8'hFE, 8'hFD, 8'hF0, 8'h10, 8'h7F, 8'h80};
    ackQ = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    doPoll("analog", 9, 16'hFDFE);
    analog_mode = 1'b0;
`else
    $display("[TB] analog_mode ignored without analog build");
    buttons     = 16'hFDFE;
    sticks      = 32'h807F_10F0;
    analog_mode = 1'b1;
    txQ  = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    expQ = '{8'hFF, 8'h41, 8'h5A, 8'hFE, 8'hFD, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    ackQ = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    doPoll("noAnalog", 5, 16'hFDFE);
    analog_mode = 1'b0;
`endif

    $display("[TB] wrong address then valid poll");
    txQ  = '{8'h81, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    expQ = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    ackQ = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    doPoll("badAddr", 2, 16'hFDFE);
    buttons = 16'hA55A;
    txQ  = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    expQ = '{8'hFF, 8'h41, 8'h5A, 8'h5A, 8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    ackQ = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    doPoll("afterBad", 5, 16'h1234);

    $display("[TB] wrong command");
    txQ  = '{8'h01, 8'h43, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    expQ = '{8'hFF, 8'h41, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    ackQ = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    doPoll("badCmd", 3, 16'hFDFE);

    $display("[TB] abort during ack pulse");
    buttons = 16'hFDFE;
    @(negedge clk);
    ifc.att = 1'b0;
    repeat (16) @(negedge clk);
    applyStimulus("abort_b0", 8'h01, 8'hFF, 1'b1, 1'b0);
    applyStimulus("abort_b1", 8'h42, 8'h41, 1'b1, 1'b0);
    applyStimulus("abort_b2", 8'h00, 8'h5A, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("abort_ackHold", 32'(ifc.ack), 32'd0);
    @(negedge clk);
    checkOutput("abort_ack", 32'(ifc.ack), 32'd1);
    checkOutput("abort_data", 32'(ifc.data), 32'd1);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    repeat (20) @(negedge clk);
    checkOutput("abort_ackStays", 32'(ifc.ack), 32'd1);

    $display("[TB] reset mid-transaction");
    @(negedge clk);
    ifc.att = 1'b0;
    repeat (16) @(negedge clk);
    applyStimulus("rst_b0", 8'h01, 8'hFF, 1'b1, 1'b0);
    applyStimulus("rst_b1", 8'h42, 8'h41, 1'b1, 1'b0);
    @(negedge clk);
    ifc.psx_clk = 1'b0;
    ifc.cmd     = 1'b0;
    repeat (HALF_BIT) @(negedge clk);
    checkOutput("rst_preData", 32'(ifc.data), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_data", 32'(ifc.data), 32'd1);
    checkOutput("rst_ack", 32'(ifc.ack), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    rst         = 1'b0;
    ifc.att     = 1'b1;
    ifc.psx_clk = 1'b1;
    ifc.cmd     = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("rst_busyAfter", 32'(busy), 32'd0);
    buttons = 16'hFDFE;
    txQ  = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    expQ = '{8'hFF, 8'h41, 8'h5A, 8'hFE, 8'hFD, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    ackQ = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    doPoll("afterRst", 5, 16'hFDFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
